// File: rtl/potential_decay_engine_if.sv
// Bus bundle for potential_decay_engine.
//  master: sweep control (model, decay_rate, timestep), init/add write requests,
//          out_ready; observes ready flags, the decayed-potential stream and status.
//  slave : the engine side of the same signals.
interface potential_decay_engine_if #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = $clog2(NUM_NEURONS),
  parameter int unsigned RATE_W      = 4
);
  logic [1:0]        model;
  logic [RATE_W-1:0] decay_rate;
  logic              timestep;
  logic              init_valid;
  logic              init_ready;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_potential;
  logic              add_valid;
  logic              add_ready;
  logic [ADDR_W-1:0] add_addr;
  logic [DATA_W-1:0] add_weight;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_potential;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output model, decay_rate, timestep,
    output init_valid, init_addr, init_potential,
    output add_valid, add_addr, add_weight,
    output out_ready,
    input  init_ready, add_ready,
    input  out_valid, out_addr, out_potential,
    input  busy, done, overrun
  );

  modport slave (
    input  model, decay_rate, timestep,
    input  init_valid, init_addr, init_potential,
    input  add_valid, add_addr, add_weight,
    input  out_ready,
    output init_ready, add_ready,
    output out_valid, out_addr, out_potential,
    output busy, done, overrun
  );
endinterface

// File: rtl/potential_decay_engine.sv
// Time-multiplexed membrane-potential store and leak unit.
// Holds NUM_NEURONS signed potentials, sweeps them once per timestep applying
// the latched leak model, streams each decayed value out and writes it back.
// Between sweeps it accepts init writes and saturating synaptic accumulations.
// Ports:
//  i_clk    clock, all logic on posedge
//  i_reset  synchronous, active-high
//  io_bus   slave side of potential_decay_engine_if (control, writes, output stream, status)
module potential_decay_engine #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = $clog2(NUM_NEURONS),
  parameter int unsigned RATE_W      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  potential_decay_engine_if.slave  io_bus
);

  localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
  logic [1:0]          r_model, w_model_nxt;
  logic [RATE_W-1:0]   r_rate, w_rate_nxt;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun, w_overrun_nxt;
  logic signed [DATA_W-1:0] r_mem [NUM_NEURONS];

  logic                w_init_fire, w_add_fire, w_out_fire;
  logic                w_init_in_range, w_add_in_range;
  logic signed [DATA_W-1:0] w_rd, w_shift, w_decayed;
  logic signed [DATA_W-1:0] w_add_cur, w_add_sat;
  logic [DATA_W:0]          w_add_sum;

  // Handshakes; init wins over add when both request in IDLE
  assign w_init_fire     = (r_state == S_IDLE) && io_bus.init_valid;
  assign w_add_fire      = (r_state == S_IDLE) && io_bus.add_valid && !io_bus.init_valid;
  assign w_out_fire      = r_out_valid && io_bus.out_ready;
  assign w_init_in_range = 32'(io_bus.init_addr) < NUM_NEURONS;
  assign w_add_in_range  = 32'(io_bus.add_addr) < NUM_NEURONS;

  // Leak on the current sweep entry; >>> floors, so negatives settle at -1
  always_comb begin
    w_rd    = r_mem[r_idx];
    w_shift = w_rd >>> r_rate;
    case (r_model)
      2'b00:   w_decayed = w_rd - w_shift;
      2'b10:   w_decayed = w_shift;
      default: w_decayed = w_rd;
    endcase
  end

  // Saturating accumulate: one guard bit detects signed overflow
  always_comb begin
    w_add_cur = r_mem[io_bus.add_addr];
    w_add_sum = {w_add_cur[DATA_W-1], w_add_cur} + {io_bus.add_weight[DATA_W-1], io_bus.add_weight};
    if (w_add_sum[DATA_W] != w_add_sum[DATA_W-1]) begin
      w_add_sat = w_add_sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      w_add_sat = w_add_sum[DATA_W-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_model_nxt   = r_model;
    w_rate_nxt    = r_rate;
    w_overrun_nxt = r_overrun;
    case (r_state)
      S_IDLE: begin
        if (io_bus.timestep) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = '0;
          w_model_nxt = io_bus.model;
          w_rate_nxt  = io_bus.decay_rate;
        end
      end
      S_SWEEP: begin
        if (io_bus.timestep) w_overrun_nxt = 1'b1;
        if (w_out_fire) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        if (io_bus.timestep) w_overrun_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_model     <= '0;
      r_rate      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_model     <= w_model_nxt;
      r_rate      <= w_rate_nxt;
      r_out_valid <= (w_state_nxt == S_SWEEP);
      r_busy      <= (w_state_nxt == S_SWEEP);
      r_done      <= (w_state_nxt == S_DONE);
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Potential store; write sources are mutually exclusive by state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
    end else if (w_out_fire) begin
      r_mem[r_idx] <= w_decayed;
    end else if (w_init_fire && w_init_in_range) begin
      r_mem[io_bus.init_addr] <= io_bus.init_potential;
    end else if (w_add_fire && w_add_in_range) begin
      r_mem[io_bus.add_addr] <= w_add_sat;
    end
  end

  assign io_bus.init_ready    = (r_state == S_IDLE);
  assign io_bus.add_ready     = (r_state == S_IDLE) && !io_bus.init_valid;
  assign io_bus.out_valid     = r_out_valid;
  assign io_bus.out_addr      = r_idx;
  assign io_bus.out_potential = r_out_valid ? w_decayed : '0;
  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;
  assign io_bus.overrun       = r_overrun;

endmodule
